// File: rtl/sll32_pkg.sv
// sll32_pkg
// Shared definitions for the sequential left shifter: default widths, the
// stage-counter width and the FSM state encoding.
package sll32_pkg;

  // Operand/result width and shift-amount width defaults.
  // The shift-amount width must equal clog2 of the operand width.
  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  // Stage index width. It also sets the width of the k input of
  // sll32_stage, so 3 bits cover up to 8 stages (operands up to 256 bits).
  localparam int STAGE_W = 3;

  // S_UNUSED never occurs in normal operation. If it is ever reached,
  // the FSM recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_DONE   = 2'd2,
    S_UNUSED = 2'd3
  } state_t;

endpackage

// File: rtl/sll32_stage.sv
// sll32_stage
// One conditional power-of-two left-shift stage (combinational).
// Ports:
//   d  in  WIDTH  value to shift
//   en in  1      apply the shift when high, pass d through otherwise
//   k  in  3      stage index; the shift distance is 1<<k
//   q  out WIDTH  d<<(1<<k) when en, else d; vacated LSBs are zero
module sll32_stage
  import sll32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   d,
  input  logic               en,
  input  logic [STAGE_W-1:0] k,
  output logic [WIDTH-1:0]   q
);

  // The distance can reach 1<<7 = 128. A distance of WIDTH or more
  // shifts everything out, which gives the zero-fill result we want.
  logic [7:0] w_dist;

  assign w_dist = 8'd1 << k;
  assign q      = en ? (d << w_dist) : d;

endmodule

// File: rtl/sll32_seq.sv
// sll32_seq
// Sequential logical left shifter. It applies one power-of-two stage per
// clock and always takes five stage cycles. Results are zero-filled and
// truncated to WIDTH.
// Ports:
//   clk        in  1        rising-edge clock
//   rst_n      in  1        asynchronous active-low reset
//   in_valid   in  1        A/B valid
//   in_ready   out 1        high only in IDLE
//   A          in  WIDTH    operand
//   B          in  SHAMT_W  shift amount
//   out_valid  out 1        res holds the final result (DONE)
//   out_ready  in  1        consumer accepts res
//   res        out WIDTH    working/result register
//   busy       out 1        high in SHIFT or DONE
module sll32_seq
  import sll32_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   res,
  output logic               busy
);

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(SHAMT_W - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_res;
  logic [SHAMT_W-1:0]   r_amt;
  logic [STAGE_W-1:0]   r_stage;
  logic                 w_stage_en;
  logic [WIDTH-1:0]     w_stage_q;
  logic                 w_accept;

  // All handshake outputs are decoded from the state register only.
  // This keeps out_ready away from in_ready combinationally.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign res       = r_res;

  assign w_accept  = in_valid && (r_state == S_IDLE);

  // Select bit amt[stage] with a one-hot mask. r_stage runs past the last
  // stage after SHIFT ends, and the mask then yields 0 instead of an
  // out-of-range index.
  assign w_stage_en = |(r_amt & (SHAMT_W'(1) << r_stage));

  sll32_stage #(
    .WIDTH(WIDTH)
  ) u_stage (
    .d (r_res),
    .en(w_stage_en),
    .k (r_stage),
    .q (w_stage_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_SHIFT;
      S_SHIFT: if (r_stage == LAST_STAGE) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res   <= '0;
      r_amt   <= '0;
      r_stage <= '0;
    end else begin
      if (w_accept) begin
        r_res   <= A;
        r_amt   <= B;
        r_stage <= '0;
      end else if (r_state == S_SHIFT) begin
        r_res   <= w_stage_q;
        r_stage <= r_stage + 1'b1;
      end
    end
  end

endmodule
